// File: rtl/cpu6502_alu_sequencer.sv
// Multi-cycle sequencer for 6502 group-1 (cc=01) instructions.
// It owns the accumulator and the N/V/Z/C flags, fetches zero-page operands and drives an external combinational ALU.
module cpu6502_alu_sequencer #(
  parameter logic [7:0] ACC_RESET = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_op_valid,
  output logic       o_op_ready,
  input  logic [7:0] i_opcode,
  input  logic [7:0] i_operand,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic [7:0] o_mem_addr,
  output logic [7:0] o_mem_wdata,
  input  logic [7:0] i_mem_rdata,
  input  logic       i_mem_ack,
  output logic [7:0] o_alu_operand1,
  output logic [7:0] o_alu_operand2,
  output logic       o_alu_carry_in,
  output logic [4:0] o_alu_operation,
  input  logic [7:0] i_alu_result,
  input  logic       i_alu_carry_out,
  output logic [7:0] o_acc,
  output logic       o_flag_n,
  output logic       o_flag_v,
  output logic       o_flag_z,
  output logic       o_flag_c,
  output logic       o_done,
  output logic       o_illegal
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EXEC,
    WRITE,
    WPOST,
    DONE
  } state_t;

  localparam logic [2:0] AAA_ADC = 3'b011;
  localparam logic [2:0] AAA_STA = 3'b100;
  localparam logic [2:0] AAA_CMP = 3'b110;
  localparam logic [2:0] AAA_SBC = 3'b111;
  localparam logic [4:0] OP_ADD  = 5'b01101;

  state_t     r_state;
  state_t     w_nextState;
  logic [2:0] r_aaa;
  logic [1:0] r_cc;
  logic [7:0] r_operand;
  logic [7:0] r_mem;
  logic       r_illegal;
  logic [7:0] r_acc;
  logic       r_flagN;
  logic       r_flagV;
  logic       r_flagZ;
  logic       r_flagC;

  logic       w_inIllegal;
  logic       w_inImmediate;
  logic       w_inStore;
  logic       w_accept;
  logic       w_isAdc;
  logic       w_isSbc;
  logic       w_isCmp;
  logic [7:0] w_op1;
  logic [7:0] w_op2;
  logic       w_cin;
  logic [4:0] w_operation;

  assign w_inIllegal   = (i_opcode[1:0] != 2'b01) || (i_opcode == 8'h89);
  assign w_inImmediate = (i_opcode[4:2] == 3'b010);
  assign w_inStore     = (i_opcode[7:5] == AAA_STA);
  assign w_accept      = (r_state == IDLE) && i_op_valid;

  assign w_isAdc = (r_aaa == AAA_ADC);
  assign w_isSbc = (r_aaa == AAA_SBC);
  assign w_isCmp = (r_aaa == AAA_CMP);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    o_op_ready  = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_done      = 1'b0;
    o_illegal   = 1'b0;
    case (r_state)
      IDLE: begin
        o_op_ready = 1'b1;
        if (i_op_valid) begin
          if (w_inIllegal) begin
            w_nextState = DONE;
          end else if (w_inImmediate) begin
            w_nextState = EXEC;
          end else if (w_inStore) begin
            w_nextState = WRITE;
          end else begin
            w_nextState = READ;
          end
        end
      end
      READ: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          w_nextState = EXEC;
        end
      end
      EXEC: begin
        w_nextState = DONE;
      end
      WRITE: begin
        o_mem_req = 1'b1;
        o_mem_we  = 1'b1;
        if (i_mem_ack) begin
          w_nextState = WPOST;
        end
      end
      // A settle cycle after the write ack gives stores the same latency as reads.
      WPOST: begin
        w_nextState = DONE;
      end
      DONE: begin
        o_done      = 1'b1;
        o_illegal   = r_illegal;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Subtract-style ops reuse the adder with the inverted operand.
  always_comb begin
    w_op1       = 8'h00;
    w_op2       = 8'h00;
    w_cin       = 1'b0;
    w_operation = 5'b00000;
    if (r_state == EXEC) begin
      w_op1 = r_acc;
      w_op2 = (w_isSbc || w_isCmp) ? ~r_mem : r_mem;
      w_cin = w_isCmp ? 1'b1 : r_flagC;
      if (w_isAdc || w_isSbc || w_isCmp) begin
        w_operation = OP_ADD;
      end else begin
        w_operation = {r_aaa, r_cc};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_aaa     <= 3'b000;
      r_cc      <= 2'b00;
      r_operand <= 8'h00;
      r_mem     <= 8'h00;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_aaa     <= i_opcode[7:5];
      r_cc      <= i_opcode[1:0];
      r_operand <= i_operand;
      r_mem     <= i_operand;
      r_illegal <= w_inIllegal;
    end else if ((r_state == READ) && i_mem_ack) begin
      r_mem <= i_mem_rdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc   <= ACC_RESET;
      r_flagN <= 1'b0;
      r_flagV <= 1'b0;
      r_flagZ <= 1'b0;
      r_flagC <= 1'b0;
    end else if (r_state == EXEC) begin
      if (!w_isCmp) begin
        r_acc <= i_alu_result;
      end
      r_flagN <= i_alu_result[7];
      r_flagZ <= (i_alu_result == 8'h00);
      if (w_isAdc || w_isSbc || w_isCmp) begin
        r_flagC <= i_alu_carry_out;
      end
      if (w_isAdc || w_isSbc) begin
        r_flagV <= (w_op1[7] == w_op2[7]) && (i_alu_result[7] != w_op1[7]);
      end
    end
  end

  assign o_mem_addr      = r_operand;
  assign o_mem_wdata     = r_acc;
  assign o_alu_operand1  = w_op1;
  assign o_alu_operand2  = w_op2;
  assign o_alu_carry_in  = w_cin;
  assign o_alu_operation = w_operation;
  assign o_acc           = r_acc;
  assign o_flag_n        = r_flagN;
  assign o_flag_v        = r_flagV;
  assign o_flag_z        = r_flagZ;
  assign o_flag_c        = r_flagC;

endmodule

// File: tb/tb_cpu6502_alu_sequencer.sv
// Self-checking bench for cpu6502_alu_sequencer: external ALU and zero-page memory models plus a 6502 reference model.
// Expected results are queued when an op is issued and popped when the done pulse appears.
module tb_cpu6502_alu_sequencer;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_op_valid;
  logic       o_op_ready;
  logic [7:0] i_opcode;
  logic [7:0] i_operand;
  logic       o_mem_req;
  logic       o_mem_we;
  logic [7:0] o_mem_addr;
  logic [7:0] o_mem_wdata;
  logic [7:0] i_mem_rdata;
  logic       i_mem_ack;
  logic [7:0] o_alu_operand1;
  logic [7:0] o_alu_operand2;
  logic       o_alu_carry_in;
  logic [4:0] o_alu_operation;
  logic [7:0] i_alu_result;
  logic       i_alu_carry_out;
  logic [7:0] o_acc;
  logic       o_flag_n;
  logic       o_flag_v;
  logic       o_flag_z;
  logic       o_flag_c;
  logic       o_done;
  logic       o_illegal;

  always #5 clk = ~clk;

  cpu6502_alu_sequencer #(.ACC_RESET(8'h00)) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_op_valid(i_op_valid),
    .o_op_ready(o_op_ready),
    .i_opcode(i_opcode),
    .i_operand(i_operand),
    .o_mem_req(o_mem_req),
    .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata),
    .i_mem_ack(i_mem_ack),
    .o_alu_operand1(o_alu_operand1),
    .o_alu_operand2(o_alu_operand2),
    .o_alu_carry_in(o_alu_carry_in),
    .o_alu_operation(o_alu_operation),
    .i_alu_result(i_alu_result),
    .i_alu_carry_out(i_alu_carry_out),
    .o_acc(o_acc),
    .o_flag_n(o_flag_n),
    .o_flag_v(o_flag_v),
    .o_flag_z(o_flag_z),
    .o_flag_c(o_flag_c),
    .o_done(o_done),
    .o_illegal(o_illegal)
  );

  // Combinational ALU the sequencer drives.
  logic [8:0] aluSum;
  always_comb begin
    i_alu_result    = 8'h00;
    i_alu_carry_out = 1'b0;
    aluSum = {1'b0, o_alu_operand1} + {1'b0, o_alu_operand2} + {8'h00, o_alu_carry_in};
    case (o_alu_operation)
      5'b00001: i_alu_result = o_alu_operand1 | o_alu_operand2;
      5'b00101: i_alu_result = o_alu_operand1 & o_alu_operand2;
      5'b01001: i_alu_result = o_alu_operand1 ^ o_alu_operand2;
      5'b01101: begin
        i_alu_result    = aluSum[7:0];
        i_alu_carry_out = aluSum[8];
      end
      5'b10101: i_alu_result = o_alu_operand2;
      default: i_alu_result = 8'h00;
    endcase
  end

  typedef struct {
    logic [7:0] acc;
    logic       n;
    logic       v;
    logic       z;
    logic       c;
    logic       ill;
    int         lat;
    int         reqs;
    logic       store;
    logic [7:0] wdata;
  } expT;

  expT        sbQ[$];
  logic [7:0] tbMem [256];
  logic [7:0] mAcc;
  logic       mN;
  logic       mV;
  logic       mZ;
  logic       mC;
  int         checks = 0;
  int         errors = 0;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input int lat, input int reqs, input logic [7:0] wdata, input logic sawDone);
    expT e;
    checkValue("done_seen", {31'd0, sawDone}, 32'd1);
    if (sbQ.size() == 0) begin
      checkValue("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sbQ.pop_front();
    if (sawDone) begin
      checkValue("acc", {24'd0, o_acc}, {24'd0, e.acc});
      checkValue("flag_n", {31'd0, o_flag_n}, {31'd0, e.n});
      checkValue("flag_v", {31'd0, o_flag_v}, {31'd0, e.v});
      checkValue("flag_z", {31'd0, o_flag_z}, {31'd0, e.z});
      checkValue("flag_c", {31'd0, o_flag_c}, {31'd0, e.c});
      checkValue("illegal", {31'd0, o_illegal}, {31'd0, e.ill});
      checkValue("latency", lat, e.lat);
    end
    checkValue("req_cycles", reqs, e.reqs);
    if (e.store) checkValue("mem_wdata", {24'd0, wdata}, {24'd0, e.wdata});
  endtask

  // Reference 6502 model computes the expectation; then the op is issued and the memory side is served.
  task automatic applyStimulus(input logic [7:0] op, input logic [7:0] opnd, input int reqN, input bit poke);
    expT        e;
    logic [7:0] m;
    logic [7:0] t;
    logic [8:0] s;
    int         reqCount;
    int         lat;
    logic [7:0] wseen;
    logic       sawDone;
    e.ill = (op[1:0] != 2'b01) || (op == 8'h89);
    e.store = 1'b0;
    e.wdata = 8'h00;
    e.reqs  = 0;
    e.lat   = 1;
    if (!e.ill) begin
      m = (op[4:2] == 3'b010) ? opnd : tbMem[opnd];
      e.reqs = (op[4:2] == 3'b010) ? 0 : reqN;
      e.lat  = (op[4:2] == 3'b010) ? 2 : reqN + 2;
      case (op[7:5])
        3'd0: mAcc = mAcc | m;
        3'd1: mAcc = mAcc & m;
        3'd2: mAcc = mAcc ^ m;
        3'd3: begin
          s  = {1'b0, mAcc} + {1'b0, m} + {8'd0, mC};
          t  = ~(mAcc ^ m) & (mAcc ^ s[7:0]);
          mV = t[7];
          mC = s[8];
          mAcc = s[7:0];
        end
        3'd4: begin
          e.store = 1'b1;
          e.wdata = mAcc;
          tbMem[opnd] = mAcc;
        end
        3'd5: mAcc = m;
        3'd6: begin
          t  = mAcc - m;
          mC = (mAcc >= m);
          mN = t[7];
          mZ = (mAcc == m);
        end
        default: begin
          s  = {1'b0, mAcc} - {1'b0, m} - {8'd0, ~mC};
          t  = (mAcc ^ m) & (mAcc ^ s[7:0]);
          mV = t[7];
          mC = ~s[8];
          mAcc = s[7:0];
        end
      endcase
      if (op[7:5] != 3'd4 && op[7:5] != 3'd6) begin
        mN = mAcc[7];
        mZ = (mAcc == 8'h00);
      end
    end
    e.acc = mAcc;
    e.n = mN;
    e.v = mV;
    e.z = mZ;
    e.c = mC;
    sbQ.push_back(e);

    @(negedge clk);
    checkValue("op_ready", {31'd0, o_op_ready}, 32'd1);
    checkValue("done_idle", {31'd0, o_done}, 32'd0);
    i_opcode   = op;
    i_operand  = opnd;
    i_op_valid = 1'b1;
    @(posedge clk);
    #1 i_op_valid = 1'b0;
    reqCount = 0;
    lat = 0;
    wseen = 8'h00;
    sawDone = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      i_mem_ack  = 1'b0;
      i_op_valid = 1'b0;
      if (poke && k == 1) begin
        i_op_valid = 1'b1;
        i_opcode   = 8'hA9;
        i_operand  = 8'hEE;
        if (!o_mem_req) begin
          i_mem_ack   = 1'b1;
          i_mem_rdata = 8'h77;
        end
      end
      if (o_mem_req) begin
        reqCount++;
        checkValue("mem_addr", {24'd0, o_mem_addr}, {24'd0, opnd});
        checkValue("mem_we", {31'd0, o_mem_we}, {31'd0, e.store});
        checkValue("alu_idle", {10'd0, o_alu_operand1, o_alu_operand2, o_alu_carry_in, o_alu_operation}, 32'd0);
        if (reqCount == reqN) begin
          i_mem_ack   = 1'b1;
          i_mem_rdata = tbMem[o_mem_addr];
          if (o_mem_we) wseen = o_mem_wdata;
        end
      end
      if (o_done) begin
        lat = k;
        sawDone = 1'b1;
        break;
      end
    end
    i_op_valid = 1'b0;
    i_mem_ack  = 1'b0;
    checkOutput(lat, reqCount, wseen, sawDone);
  endtask

  initial begin
    i_reset     = 1'b1;
    i_op_valid  = 1'b0;
    i_opcode    = 8'h00;
    i_operand   = 8'h00;
    i_mem_rdata = 8'h00;
    i_mem_ack   = 1'b0;
    for (int a = 0; a < 256; a++) tbMem[a] = 8'(a * 7 + 3);
    mAcc = 8'h00;
    {mN, mV, mZ, mC} = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkValue("rst_ready", {31'd0, o_op_ready}, 32'd1);
    checkValue("rst_bus", {29'd0, o_mem_req, o_mem_we, o_done}, 32'd0);
    checkValue("rst_illegal", {31'd0, o_illegal}, 32'd0);
    checkValue("rst_acc", {24'd0, o_acc}, 32'd0);
    checkValue("rst_flags", {28'd0, o_flag_n, o_flag_v, o_flag_z, o_flag_c}, 32'd0);
    i_reset = 1'b0;

    applyStimulus(8'hA9, 8'h80, 0, 1'b0);
    applyStimulus(8'hA9, 8'h7F, 0, 1'b0);
    applyStimulus(8'h69, 8'h01, 0, 1'b0);
    applyStimulus(8'hC9, 8'h00, 0, 1'b0);
    applyStimulus(8'hA9, 8'h00, 0, 1'b0);
    applyStimulus(8'hE9, 8'h01, 0, 1'b0);
    applyStimulus(8'hA9, 8'h40, 0, 1'b0);
    tbMem[8'h10] = 8'h40;
    applyStimulus(8'hC5, 8'h10, 3, 1'b0);
    applyStimulus(8'hA9, 8'h5A, 0, 1'b0);
    applyStimulus(8'h85, 8'h20, 1, 1'b1);
    tbMem[8'h33] = 8'h0F;
    applyStimulus(8'h25, 8'h33, 2, 1'b0);
    applyStimulus(8'h09, 8'hF0, 0, 1'b1);
    tbMem[8'h44] = 8'hFA;
    applyStimulus(8'h45, 8'h44, 1, 1'b0);
    tbMem[8'h55] = 8'hFF;
    applyStimulus(8'h65, 8'h55, 1, 1'b0);
    applyStimulus(8'h89, 8'h00, 0, 1'b1);
    applyStimulus(8'hA8, 8'h12, 0, 1'b0);
    applyStimulus(8'h6A, 8'h12, 0, 1'b0);
    tbMem[8'h66] = 8'hC3;
    applyStimulus(8'hA5, 8'h66, 1, 1'b0);
    applyStimulus(8'hE5, 8'h55, 2, 1'b0);

    @(negedge clk);
    i_opcode   = 8'hA5;
    i_operand  = 8'h30;
    i_op_valid = 1'b1;
    @(posedge clk);
    #1 i_op_valid = 1'b0;
    @(negedge clk);
    checkValue("mid_req", {31'd0, o_mem_req}, 32'd1);
    i_reset = 1'b1;
    @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    mAcc = 8'h00;
    {mN, mV, mZ, mC} = 4'b0000;
    checkValue("abort_req", {31'd0, o_mem_req}, 32'd0);
    checkValue("abort_ready", {31'd0, o_op_ready}, 32'd1);
    checkValue("abort_acc", {24'd0, o_acc}, {24'd0, mAcc});
    checkValue("abort_flags", {28'd0, o_flag_n, o_flag_v, o_flag_z, o_flag_c}, 32'd0);

    applyStimulus(8'hA9, 8'h01, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
